// File: rtl/despachante_instrucoes.sv
// Instruction dispatcher: pulls instructions from fila_de_instrucoes,
// allocates reservation stations and tracks register producer tags.
module despachante_instrucoes #(
    parameter int N_REGS = 8,
    parameter int TAG_W  = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Fila_Empty,
    input  logic [15:0]      Fila_Instrucao,
    output logic             Fila_ReadEnable,
    input  logic [6:0]       RS_Free,
    input  logic             CDB_Valid,
    input  logic [TAG_W-1:0] CDB_Tag,
    output logic             Issue_Valid,
    output logic [TAG_W-1:0] Issue_Tag,
    output logic [3:0]       Issue_Op,
    output logic [2:0]       Issue_Rd,
    output logic [2:0]       Issue_Rs,
    output logic [2:0]       Issue_Rt,
    output logic [TAG_W-1:0] Issue_Qj,
    output logic [TAG_W-1:0] Issue_Qk,
    output logic             Stall
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } estado_t;

    estado_t          estado_q;
    logic [15:0]      instr_q;
    logic [TAG_W-1:0] qi_q [N_REGS];

    logic             re_q;
    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       op_q;
    logic [2:0]       rd_q;
    logic [2:0]       rs_q;
    logic [2:0]       rt_q;
    logic [TAG_W-1:0] qj_q;
    logic [TAG_W-1:0] qk_q;
    logic             stall_q;

    logic [3:0]       op_w;
    logic [2:0]       rd_w;
    logic [2:0]       rs_w;
    logic [2:0]       rt_w;
    logic [TAG_W-1:0] tag_d;
    logic             op_valido_d;
    logic             eh_st_d;
    logic             eh_ld_d;
    logic [TAG_W-1:0] qj_d;
    logic [TAG_W-1:0] qk_d;

    assign op_w = instr_q[15:12];
    assign rd_w = instr_q[11:9];
    assign rs_w = instr_q[8:6];
    assign rt_w = instr_q[5:3];

    // Decode held instruction and pick lowest free station of its class
    always_comb begin
        tag_d       = '0;
        op_valido_d = 1'b1;
        eh_st_d     = 1'b0;
        eh_ld_d     = 1'b0;
        case (op_w)
            4'd0, 4'd1: begin
                if (RS_Free[0])      tag_d = TAG_W'(1);
                else if (RS_Free[1]) tag_d = TAG_W'(2);
                else if (RS_Free[2]) tag_d = TAG_W'(3);
            end
            4'd2: begin
                if (RS_Free[3])      tag_d = TAG_W'(4);
                else if (RS_Free[4]) tag_d = TAG_W'(5);
            end
            4'd3, 4'd4: begin
                eh_ld_d = (op_w == 4'd3);
                eh_st_d = (op_w == 4'd4);
                if (RS_Free[5])      tag_d = TAG_W'(6);
                else if (RS_Free[6]) tag_d = TAG_W'(7);
            end
            default: op_valido_d = 1'b0;
        endcase
    end

    // Operand tags with same-cycle CDB bypass
    always_comb begin
        qj_d = qi_q[rs_w];
        qk_d = qi_q[rt_w];
        if (CDB_Valid && (qj_d == CDB_Tag)) qj_d = '0;
        if (CDB_Valid && (qk_d == CDB_Tag)) qk_d = '0;
        if (eh_ld_d) qk_d = '0;
    end

    // Dispatch FSM, register status table and registered outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_q <= FETCH;
            instr_q  <= '0;
            re_q     <= 1'b0;
            valid_q  <= 1'b0;
            tag_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            qj_q     <= '0;
            qk_q     <= '0;
            stall_q  <= 1'b0;
            for (int i = 0; i < N_REGS; i++) qi_q[i] <= '0;
        end else begin
            re_q    <= 1'b0;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            if (CDB_Valid) begin
                for (int i = 0; i < N_REGS; i++)
                    if (qi_q[i] == CDB_Tag) qi_q[i] <= '0;
            end
            case (estado_q)
                FETCH: begin
                    if (!Fila_Empty) begin
                        re_q     <= 1'b1;
                        estado_q <= WAIT;
                    end
                end
                WAIT: begin
                    instr_q  <= Fila_Instrucao;
                    estado_q <= ISSUE;
                end
                ISSUE: begin
                    if (!op_valido_d) begin
                        estado_q <= FETCH;
                    end else if (tag_d != '0) begin
                        valid_q  <= 1'b1;
                        tag_q    <= tag_d;
                        op_q     <= op_w;
                        rd_q     <= rd_w;
                        rs_q     <= rs_w;
                        rt_q     <= rt_w;
                        qj_q     <= qj_d;
                        qk_q     <= qk_d;
                        if (!eh_st_d) qi_q[rd_w] <= tag_d;
                        estado_q <= FETCH;
                    end else begin
                        stall_q <= 1'b1;
                    end
                end
                default: estado_q <= FETCH;
            endcase
        end
    end

    assign Fila_ReadEnable = re_q;
    assign Issue_Valid     = valid_q;
    assign Issue_Tag       = tag_q;
    assign Issue_Op        = op_q;
    assign Issue_Rd        = rd_q;
    assign Issue_Rs        = rs_q;
    assign Issue_Rt        = rt_q;
    assign Issue_Qj        = qj_q;
    assign Issue_Qk        = qk_q;
    assign Stall           = stall_q;

endmodule

// File: tb/tb_despachante_instrucoes.sv
// Bench for despachante_instrucoes: show-ahead queue emulation,
// directed scenarios and a randomized run against a table model.
module tb_despachante_instrucoes;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Fila_Empty = 1'b1;
    logic [15:0] Fila_Instrucao = 16'h0;
    logic        Fila_ReadEnable;
    logic [6:0]  RS_Free = 7'h7F;
    logic        CDB_Valid = 1'b0;
    logic [2:0]  CDB_Tag = 3'd0;
    logic        Issue_Valid;
    logic [2:0]  Issue_Tag;
    logic [3:0]  Issue_Op;
    logic [2:0]  Issue_Rd;
    logic [2:0]  Issue_Rs;
    logic [2:0]  Issue_Rt;
    logic [2:0]  Issue_Qj;
    logic [2:0]  Issue_Qk;
    logic        Stall;

    int total = 0;
    int bad = 0;

    logic [15:0] fifo [$];
    bit pop_pend = 0;

    despachante_instrucoes dut (
        .Clock(Clock), .Reset(Reset),
        .Fila_Empty(Fila_Empty), .Fila_Instrucao(Fila_Instrucao),
        .Fila_ReadEnable(Fila_ReadEnable), .RS_Free(RS_Free),
        .CDB_Valid(CDB_Valid), .CDB_Tag(CDB_Tag),
        .Issue_Valid(Issue_Valid), .Issue_Tag(Issue_Tag),
        .Issue_Op(Issue_Op), .Issue_Rd(Issue_Rd),
        .Issue_Rs(Issue_Rs), .Issue_Rt(Issue_Rt),
        .Issue_Qj(Issue_Qj), .Issue_Qk(Issue_Qk),
        .Stall(Stall)
    );

    always #5 Clock = ~Clock;

    // Queue emulation: head visible while ReadEnable is high, popped next
    // cycle, Empty updated after the pop (one cycle behind the count).
    always @(negedge Clock) begin
        if (Reset) begin
            fifo.delete();
            pop_pend = 0;
        end else begin
            if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
            pop_pend = Fila_ReadEnable;
        end
        Fila_Empty = (fifo.size() == 0);
        if (fifo.size() > 0) Fila_Instrucao = fifo[0];
    end

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1;
        RS_Free = 7'h7F;
        CDB_Valid = 1'b0;
        CDB_Tag = 3'd0;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic wait_re(input string nm);
        int n = 0;
        while (Fila_ReadEnable !== 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (Fila_ReadEnable !== 1'b1) begin
            bad++; $display("FAIL %s_re_timeout got=%b exp=1", nm, Fila_ReadEnable);
        end
    endtask

    task automatic wait_iv(input string nm);
        int n = 0;
        while (Issue_Valid !== 1'b1 && n < 40) begin tick(); n++; end
        total++;
        if (Issue_Valid !== 1'b1) begin
            bad++; $display("FAIL %s_issue_timeout got=%b exp=1", nm, Issue_Valid);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        total++;
        if ({Fila_ReadEnable, Issue_Valid, Stall, Issue_Tag, Issue_Qj} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b exp=0",
                {Fila_ReadEnable, Issue_Valid, Stall, Issue_Tag, Issue_Qj});
        end
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({Fila_ReadEnable, Issue_Valid} !== 2'b00) begin
                bad++; $display("FAIL empty_idle cyc=%0d got=%b exp=00", i,
                    {Fila_ReadEnable, Issue_Valid});
            end
        end
    endtask

    task automatic test_add();
        do_reset();
        fifo.push_back(16'h0250);
        fifo.push_back(16'h0040);
        wait_re("add");
        tick();
        total++;
        if (Issue_Valid !== 1'b0) begin
            bad++; $display("FAIL add_early_issue got=%b exp=0", Issue_Valid);
        end
        tick();
        total++;
        if ({Issue_Valid, Issue_Tag, Issue_Op, Issue_Rd, Issue_Rs, Issue_Rt, Issue_Qj, Issue_Qk}
            !== {1'b1, 3'd1, 4'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd0}) begin
            bad++; $display("FAIL add_fields got=%b_%0d_%0d_%0d_%0d_%0d_%0d_%0d exp=1_1_0_1_1_2_0_0",
                Issue_Valid, Issue_Tag, Issue_Op, Issue_Rd, Issue_Rs, Issue_Rt, Issue_Qj, Issue_Qk);
        end
        tick();
        total++;
        if (Fila_ReadEnable !== 1'b1) begin
            bad++; $display("FAIL add_throughput got=%b exp=1", Fila_ReadEnable);
        end
        wait_iv("add2");
        total++;
        if ({Issue_Tag, Issue_Qj, Issue_Qk} !== {3'd1, 3'd1, 3'd0}) begin
            bad++; $display("FAIL add_qi1 got=%0d_%0d_%0d exp=1_1_0", Issue_Tag, Issue_Qj, Issue_Qk);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fifo.push_back(16'h2290);
        fifo.push_back(16'h0448);
        wait_iv("mul");
        total++;
        if ({Issue_Tag, Issue_Op, Issue_Rd, Issue_Qj, Issue_Qk} !== {3'd4, 4'd2, 3'd1, 3'd0, 3'd0}) begin
            bad++; $display("FAIL b2b_mul got=%0d_%0d_%0d_%0d_%0d exp=4_2_1_0_0",
                Issue_Tag, Issue_Op, Issue_Rd, Issue_Qj, Issue_Qk);
        end
        tick();
        wait_iv("add");
        total++;
        if ({Issue_Tag, Issue_Rd, Issue_Qj, Issue_Qk} !== {3'd1, 3'd2, 3'd4, 3'd4}) begin
            bad++; $display("FAIL b2b_add got=%0d_%0d_%0d_%0d exp=1_2_4_4",
                Issue_Tag, Issue_Rd, Issue_Qj, Issue_Qk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        RS_Free = 7'h1F;
        fifo.push_back(16'h3200);
        wait_re("ld");
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            total++;
            if ({Stall, Issue_Valid} !== 2'b10) begin
                bad++; $display("FAIL stall_hold cyc=%0d got=%b exp=10", i, {Stall, Issue_Valid});
            end
        end
        RS_Free = 7'h5F;
        tick();
        total++;
        if ({Issue_Valid, Stall, Issue_Tag, Issue_Op, Issue_Qk} !== {1'b1, 1'b0, 3'd7, 4'd3, 3'd0}) begin
            bad++; $display("FAIL stall_release got=%b_%b_%0d_%0d_%0d exp=1_0_7_3_0",
                Issue_Valid, Stall, Issue_Tag, Issue_Op, Issue_Qk);
        end
    endtask

    task automatic test_cdb_bypass();
        do_reset();
        RS_Free = 7'h7E;
        fifo.push_back(16'h0600);
        wait_iv("r3");
        fifo.push_back(16'h00D8);
        fifo.push_back(16'h00C0);
        tick();
        wait_re("byp");
        tick();
        CDB_Valid = 1'b1;
        CDB_Tag = 3'd2;
        tick();
        CDB_Valid = 1'b0;
        total++;
        if ({Issue_Valid, Issue_Tag, Issue_Qj, Issue_Qk} !== {1'b1, 3'd2, 3'd0, 3'd0}) begin
            bad++; $display("FAIL cdb_bypass got=%b_%0d_%0d_%0d exp=1_2_0_0",
                Issue_Valid, Issue_Tag, Issue_Qj, Issue_Qk);
        end
        tick();
        wait_iv("after");
        total++;
        if ({Issue_Qj, Issue_Qk} !== {3'd0, 3'd2}) begin
            bad++; $display("FAIL cdb_cleared got=%0d_%0d exp=0_2", Issue_Qj, Issue_Qk);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        fifo.push_back(16'h0200);
        wait_iv("first");
        RS_Free = 7'h7E;
        fifo.push_back(16'h0200);
        fifo.push_back(16'h0048);
        tick();
        wait_re("second");
        tick();
        CDB_Valid = 1'b1;
        CDB_Tag = 3'd1;
        tick();
        CDB_Valid = 1'b0;
        total++;
        if ({Issue_Valid, Issue_Tag} !== {1'b1, 3'd2}) begin
            bad++; $display("FAIL same_issue got=%b_%0d exp=1_2", Issue_Valid, Issue_Tag);
        end
        tick();
        wait_iv("reader");
        total++;
        if ({Issue_Qj, Issue_Qk} !== {3'd2, 3'd2}) begin
            bad++; $display("FAIL same_issue_wins got=%0d_%0d exp=2_2", Issue_Qj, Issue_Qk);
        end
    endtask

    task automatic test_reset_mid();
        bit pulsed = 0;
        do_reset();
        RS_Free = 7'h00;
        fifo.push_back(16'h0250);
        wait_re("mid");
        tick();
        tick();
        total++;
        if (Stall !== 1'b1) begin
            bad++; $display("FAIL mid_stall got=%b exp=1", Stall);
        end
        Reset = 1'b1;
        #1;
        total++;
        if ({Stall, Issue_Valid, Fila_ReadEnable} !== 3'b000) begin
            bad++; $display("FAIL mid_reset got=%b exp=000", {Stall, Issue_Valid, Fila_ReadEnable});
        end
        tick();
        RS_Free = 7'h7F;
        tick();
        Reset = 1'b0;
        tick();
        fifo.push_back(16'h0448);
        for (int i = 0; i < 3; i++) begin
            if (Issue_Valid === 1'b1) pulsed = 1;
            tick();
        end
        total++;
        if (pulsed) begin
            bad++; $display("FAIL mid_ghost_issue got=1 exp=0");
        end
        wait_iv("restart");
        total++;
        if ({Issue_Rd, Issue_Rs, Issue_Tag, Issue_Qj} !== {3'd2, 3'd1, 3'd1, 3'd0}) begin
            bad++; $display("FAIL mid_restart got=%0d_%0d_%0d_%0d exp=2_1_1_0",
                Issue_Rd, Issue_Rs, Issue_Tag, Issue_Qj);
        end
    endtask

    function automatic logic [2:0] pick_tag(logic [3:0] op, logic [6:0] fr);
        int lo, hi;
        if (op <= 4'd1) begin lo = 1; hi = 3; end
        else if (op == 4'd2) begin lo = 4; hi = 5; end
        else begin lo = 6; hi = 7; end
        for (int t = lo; t <= hi; t++) if (fr[t-1]) return 3'(t);
        return 3'd0;
    endfunction

    task automatic test_random();
        logic [15:0] exp_q [$];
        logic [2:0]  mqi [8];
        logic [6:0]  pfree;
        logic        pcv;
        logic [2:0]  pct;
        logic [15:0] ins;
        logic [3:0]  op;
        logic [2:0]  rd, rs, rt, et, ej, ek;
        int          issued = 0;
        int          want;
        int          cyc = 0;
        logic [3:0]  ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd9};
        do_reset();
        for (int i = 0; i < 8; i++) mqi[i] = 3'd0;
        for (int i = 0; i < 150; i++) begin
            ins = 16'($urandom);
            ins[15:12] = ops[$urandom_range(0, 6)];
            fifo.push_back(ins);
            if (ins[15:12] <= 4'd4) exp_q.push_back(ins);
        end
        want = exp_q.size();
        pfree = RS_Free; pcv = CDB_Valid; pct = CDB_Tag;
        while (issued < want && cyc < 6000) begin
            tick();
            cyc++;
            if (Issue_Valid === 1'b1) begin
                ins = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0;
                op = ins[15:12]; rd = ins[11:9]; rs = ins[8:6]; rt = ins[5:3];
                et = pick_tag(op, pfree);
                ej = (pcv && mqi[rs] == pct) ? 3'd0 : mqi[rs];
                ek = (pcv && mqi[rt] == pct) ? 3'd0 : mqi[rt];
                if (op == 4'd3) ek = 3'd0;
                total++;
                if ({Issue_Tag, Issue_Op, Issue_Rd, Issue_Rs, Issue_Rt, Issue_Qj, Issue_Qk}
                    !== {et, op, rd, rs, rt, ej, ek} || et == 3'd0) begin
                    bad++; $display("FAIL rand_issue n=%0d got=%0d_%0d_%0d_%0d_%0d_%0d_%0d exp=%0d_%0d_%0d_%0d_%0d_%0d_%0d",
                        issued, Issue_Tag, Issue_Op, Issue_Rd, Issue_Rs, Issue_Rt, Issue_Qj, Issue_Qk,
                        et, op, rd, rs, rt, ej, ek);
                end
                issued++;
                if (pcv) for (int r = 0; r < 8; r++) if (mqi[r] == pct) mqi[r] = 3'd0;
                if (op != 4'd4) mqi[rd] = et;
            end else if (pcv) begin
                for (int r = 0; r < 8; r++) if (mqi[r] == pct) mqi[r] = 3'd0;
            end
            RS_Free = 7'($urandom_range(0, 127));
            CDB_Valid = 1'($urandom_range(0, 1));
            CDB_Tag = 3'($urandom_range(0, 7));
            pfree = RS_Free; pcv = CDB_Valid; pct = CDB_Tag;
        end
        CDB_Valid = 1'b0;
        total++;
        if (issued != want) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", issued, want);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_stall();
        test_cdb_bypass();
        test_same_cycle();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/despachante_instrucoes.md
Name: despachante_instrucoes

Overview:
Consumer end of the instruction queue (fila_de_instrucoes). It pulls one 16-bit instruction per request via the queue's ReadEnable/Empty handshake, decodes it, and allocates a free reservation station of the matching class. It keeps the register status table (producer tag per architectural register), updated on issue and cleared from the common data bus (CDB). It sits between the instruction queue and the reservation stations of the Tomasulo core.

Parameters:
N_REGS, 8, number of architectural registers; indices are 3 bits, so values above 8 are not supported.
TAG_W, 3, tag width; tag 0 means "value ready, no producer".

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
Fila_Empty  input  1  Empty flag from the instruction queue (registered, lags count by one cycle)
Fila_Instrucao  input  16  Instrucao_Despachada from the queue, valid the cycle after a ReadEnable pulse
Fila_ReadEnable  output  1  one-cycle request pulse to the queue
RS_Free  input  7  bit i-1 = station with tag i free; tags 1-3 ALU, 4-5 MUL, 6-7 MEM
CDB_Valid  input  1  broadcast valid
CDB_Tag  input  3  tag of the completing station
Issue_Valid  output  1  one-cycle pulse: issue fields valid
Issue_Tag  output  3  allocated station tag
Issue_Op  output  4  opcode
Issue_Rd  output  3  destination register
Issue_Rs  output  3  first source register
Issue_Rt  output  3  second source register
Issue_Qj  output  3  producer tag of Rs, or 0
Issue_Qk  output  3  producer tag of Rt, or 0
Stall  output  1  held instruction waiting for a free station

Behaviour:
- Instruction format: [15:12] opcode, [11:9] Rd, [8:6] Rs, [5:3] Rt, [2:0] ignored.
- Opcodes: 0 ADD and 1 SUB map to ALU; 2 MUL maps to MUL; 3 LD and 4 ST map to MEM. 7 NOP, and all other opcodes, are consumed without issue.
- All outputs are registered.
- Reset values: all outputs 0, state FETCH, all Qi entries 0.
- FETCH: if Fila_Empty==0, drive Fila_ReadEnable=1 for exactly one cycle and go to WAIT. Otherwise stay in FETCH with ReadEnable=0.
- WAIT: ReadEnable=0. At the clock edge ending this cycle, latch Fila_Instrucao into the hold register and go to ISSUE. Fila_Empty is not sampled in WAIT because it is stale.
- ISSUE:
  - NOP/undefined: go to FETCH, no pulse.
  - Otherwise, choose the lowest-numbered free tag in the instruction's class.
  - If a tag is found: Issue_Valid=1 for one cycle, all fields driven from the held instruction, go to FETCH.
  - If no tag is found: Stall=1, remain in ISSUE, re-evaluate every cycle.
- Throughput: at most one instruction per 3 cycles. A new ReadEnable is never asserted while an instruction is held.
- Operand tags:
  - Qj = Qi[Rs] and Qk = Qi[Rt], sampled in the issue cycle.
  - CDB bypass: if CDB_Valid and Qi[x]==CDB_Tag, the reported tag is 0.
  - ST issues with Qj and Qk.
  - LD issues with Qk=0.
- Register status:
  - On issue of any opcode except ST: Qi[Rd] <= Issue_Tag.
  - On CDB_Valid: every Qi entry equal to CDB_Tag is cleared to 0.
  - Same-cycle CDB clear and issue write to the same Rd: the issue write wins.
  - Writes to different entries apply together.
- Stall interactions:
  - RS_Free may change while stalled; the next cycle re-selects.
  - CDB updates continue during a stall, and Qj/Qk reflect the table at the actual issue cycle.
- Reset mid-operation: a held instruction is discarded, the table is cleared, and the FSM returns to FETCH. The queue is reset by the same Reset.
- Fila_Empty is treated as advisory. If the queue did not actually pop, the stale Fila_Instrucao is re-captured. The queue's Empty lag guarantees this cannot happen when Empty is sampled only in FETCH after ISSUE.

Test Plan:
- Reset, Fila_Empty=1 for 10 cycles -> Fila_ReadEnable stays 0, Issue_Valid=0, all Qi=0.
- Queue supplies 16'h0250 (ADD R1,R1,R2), RS_Free=7'h7F:
  - ReadEnable pulses at T.
  - Issue_Valid at T+2 with Tag=1, Rd=1, Rs=1, Rt=2, Qj=0, Qk=0.
  - Qi[1] becomes 1.
- Back-to-back 16'h2290 (MUL R1,R2,R2) then 16'h0448 (ADD R2,R1,R1):
  - MUL issues Tag=4.
  - ADD issues Qj=4, Qk=4, Tag=1.
- 16'h3200 (LD R1) with RS_Free[6:5]=0:
  - Stall=1 and no pulse for 5 cycles.
  - Set RS_Free[6]=1 -> next cycle Issue_Tag=7, Stall=0.
- With Qi[3]=2, apply CDB_Valid=1, Tag=2 in the same cycle as issuing 16'h00D8 (ADD R0,R3,R3) -> Qj=0, Qk=0, Qi[3]=0.
- Same-cycle CDB clear of tag 1 and issue of a new ADD to R1 allocating tag 2 -> Qi[1]=2.
- Assert Reset while in ISSUE/Stall -> Issue_Valid never pulses, Stall=0, and the FSM restarts at FETCH after release.
